// File: rtl/datapath_polinomio.sv
// Fixed-point multiply-accumulate datapath for the six-step polynomial sequencer.
// Evaluates sum(C[k] * F[k]) with F in {1, x, x^2, 0}, saturating at every stage.
module datapath_polinomio #(
    parameter int unsigned    W    = 16,
    parameter int unsigned    FRAC = 8,
    parameter logic [W-1:0]   C0   = W'(16'h0100),
    parameter logic [W-1:0]   C1   = W'(16'h0200),
    parameter logic [W-1:0]   C2   = W'(16'h0080),
    parameter logic [W-1:0]   C3   = W'(16'h0000),
    parameter logic [W-1:0]   C4   = W'(16'hFF00),
    parameter logic [W-1:0]   C5   = W'(16'h0040)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Bandera,
    input  logic [W-1:0] dato_x,
    input  logic [2:0]   sel_const,
    input  logic [1:0]   sel_fun,
    input  logic         sel_acum,
    input  logic         Band_Listo,
    output logic [W-1:0] resultado,
    output logic         valido,
    output logic         desborde
);

    localparam int unsigned PW = 2 * W;
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ONE_V = W'(1 << FRAC);

    typedef enum logic [1:0] {IDLE, W1, W2, DONE} state_t;

    // True when a shifted double-width product does not fit in W signed bits
    function automatic logic ovf_pw(input logic signed [PW-1:0] v);
        return !((&v[PW-1:W-1]) || !(|v[PW-1:W-1]));
    endfunction

    function automatic logic signed [W-1:0] sat_pw(input logic signed [PW-1:0] v);
        if (ovf_pw(v)) return v[PW-1] ? MIN_V : MAX_V;
        return v[W-1:0];
    endfunction

    logic signed [W-1:0]  x_reg, x2, p, acc;
    logic                 acum_d, listo_d;
    state_t               state, state_nx;

    logic signed [W-1:0]  coef_c, fun_c, acc_nx_c;
    logic signed [PW-1:0] x2_full_c, prod_full_c;
    logic signed [W:0]    sum_c;
    logic                 acc_ovf_c, load_c;

    assign x2_full_c   = (PW'(x_reg) * PW'(x_reg)) >>> FRAC;
    assign prod_full_c = (PW'(coef_c) * PW'(fun_c)) >>> FRAC;
    assign sum_c       = (W+1)'(acc) + (W+1)'(p);
    assign acc_ovf_c   = sum_c[W] ^ sum_c[W-1];

    // Operand selection and accumulate/load choice
    always_comb begin
        coef_c   = '0;
        fun_c    = '0;
        acc_nx_c = p;
        case (sel_const)
            3'd0:    coef_c = C0;
            3'd1:    coef_c = C1;
            3'd2:    coef_c = C2;
            3'd3:    coef_c = C3;
            3'd4:    coef_c = C4;
            3'd5:    coef_c = C5;
            default: coef_c = '0;
        endcase
        case (sel_fun)
            2'd0:    fun_c = ONE_V;
            2'd1:    fun_c = x_reg;
            2'd2:    fun_c = x2;
            default: fun_c = '0;
        endcase
        if (acum_d) begin
            if (acc_ovf_c) acc_nx_c = sum_c[W] ? MIN_V : MAX_V;
            else           acc_nx_c = sum_c[W-1:0];
        end
    end

    // Datapath registers; Bandera restarts an evaluation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg    <= '0;
            x2       <= '0;
            p        <= '0;
            acc      <= '0;
            acum_d   <= 1'b0;
            listo_d  <= 1'b0;
            desborde <= 1'b0;
        end else begin
            x2      <= sat_pw(x2_full_c);
            listo_d <= Band_Listo;
            if (Bandera) begin
                x_reg    <= dato_x;
                p        <= '0;
                acc      <= '0;
                acum_d   <= 1'b0;
                desborde <= 1'b0;
            end else begin
                p        <= sat_pw(prod_full_c);
                acum_d   <= sel_acum;
                acc      <= acc_nx_c;
                desborde <= desborde | ovf_pw(x2_full_c) | ovf_pw(prod_full_c)
                            | (acum_d & acc_ovf_c);
            end
        end
    end

    // The final acc settles while in W1; it is captured on the way to W2 so valido is high in W2
    always_comb begin
        state_nx = state;
        load_c   = 1'b0;
        case (state)
            IDLE: if (Band_Listo && !listo_d) state_nx = W1;
            W1: begin
                state_nx = W2;
                load_c   = 1'b1;
            end
            W2:      state_nx = Band_Listo ? DONE : IDLE;
            DONE:    if (!Band_Listo) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (Bandera) begin
            state_nx = IDLE;
            load_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            resultado <= '0;
            valido    <= 1'b0;
        end else begin
            state  <= state_nx;
            valido <= load_c;
            if (load_c) resultado <= acc;
        end
    end

endmodule
